// File: rtl/readout_sequencer_pkg.sv
// Shared definitions for the readout sequencer: FSM state encoding,
// header tag and ring-buffer settle time.
package readout_sequencer_pkg;

    // Sequencer states; the encoding is also exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_HEADER  = 3'd3,
        ST_DATA    = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

    // Tag placed in the top nibble of every per-channel header word.
    localparam logic [3:0] HEADER_TAG = 4'hC;

    // Cycles the selected ring buffer needs before its output word is valid.
    localparam int SETTLE_CYCLES = 2;

endpackage : readout_sequencer_pkg

// File: rtl/readout_sequencer_rr_pick.sv
// Round-robin picker: returns the lowest set bit of the pending mask at or
// above the rr pointer, wrapping modulo NCH, plus a flag that any bit is set.
module rr_pick #(
    parameter int NCH  = 8,
    parameter int IDXW = 3
) (
    input  logic [NCH-1:0]  pending,
    input  logic [IDXW-1:0] rr,
    output logic [IDXW-1:0] index,
    output logic            any
);

    // Walk offsets from the farthest to the nearest so the nearest match wins.
    always_comb begin
        int j;
        j     = 0;
        index = '0;
        any   = |pending;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (pending[j]) begin
                index = IDXW'(j);
            end
        end
    end

endmodule : rr_pick

// File: rtl/readout_sequencer.sv
// Readout sequencer: walks the enabled channels in round-robin order and, for
// each one, emits a header word followed by how_many data words taken from the
// channel's ring buffer, pulsing spi_done to advance the buffer between words.
//
// Downstream handshake: out_valid/out_data are registered. A word transfers on
// a rising edge where out_valid and out_ready are both high. Once raised,
// out_valid and out_data stay unchanged until that transfer (only abort or
// reset may withdraw them). out_data is zero whenever out_valid is low, and
// out_ready has no effect while out_valid is low.
module readout_sequencer
    import readout_sequencer_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int SIZE  = 12,
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH-1:0]       ch_enable,
    input  logic [SIZE-1:0]      how_many,
    output logic [NCH-1:0]       read_request,
    output logic [NCH-1:0]       spi_done,
    input  logic [NCH*WIDTH-1:0] ch_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output state_e               state_dbg
);

    localparam int IDXW = $clog2(NCH);

    state_e          state;
    logic [NCH-1:0]  pending;
    logic [SIZE-1:0] hm;
    logic [SIZE-1:0] word_cnt;
    logic [IDXW-1:0] rr;
    logic [IDXW-1:0] sel;
    logic [1:0]      settle_cnt;
    logic            first_entry;

    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] hdr_word;
    logic [3:0]       sel4;
    logic [IDXW-1:0]  next_rr;
    logic [NCH-1:0]   sel_onehot;
    logic [NCH-1:0]   pick_onehot;
    logic [SIZE-1:0]  cnt_next;
    logic             xfer;
    logic             ch_complete;
    logic             abort_take;

    rr_pick #(
        .NCH  (NCH),
        .IDXW (IDXW)
    ) u_rr_pick (
        .pending (pending),
        .rr      (rr),
        .index   (pick_idx),
        .any     (pick_any)
    );

    assign state_dbg   = state;
    assign sel_word    = ch_data[int'(sel)*WIDTH +: WIDTH];
    assign sel4        = 4'(sel);
    assign next_rr     = (sel == IDXW'(NCH - 1)) ? '0 : sel + IDXW'(1);
    assign sel_onehot  = NCH'(1) << sel;
    assign pick_onehot = NCH'(1) << pick_idx;
    assign cnt_next    = word_cnt + SIZE'(1);
    assign xfer        = out_valid && out_ready;

    // An abort arriving while FINISH is already signalling done is left alone
    // so that done stays a single-cycle pulse.
    assign abort_take  = abort && (state != ST_IDLE) && (state != ST_FINISH);

    // Channel finished: header accepted with nothing to read, or last data
    // word accepted. The final word never advances the ring buffer.
    assign ch_complete = xfer && (((state == ST_HEADER) && (hm == '0)) ||
                                  ((state == ST_DATA) && (cnt_next == hm)));

    // Header word: tag in the top nibble, channel number in the bottom nibble.
    always_comb begin
        hdr_word                = '0;
        hdr_word[WIDTH-1 -: 4]  = HEADER_TAG;
        hdr_word[3:0]           = sel4;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pending      <= '0;
            hm           <= '0;
            word_cnt     <= '0;
            rr           <= '0;
            sel          <= '0;
            settle_cnt   <= '0;
            first_entry  <= 1'b0;
            read_request <= '0;
            spi_done     <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            spi_done <= '0;
            if (abort_take) begin
                read_request <= '0;
                out_valid    <= 1'b0;
                out_data     <= '0;
                pending      <= '0;
                busy         <= 1'b0;
                done         <= 1'b1;
                state        <= ST_FINISH;
            end else if (ch_complete) begin
                word_cnt     <= (state == ST_DATA) ? cnt_next : word_cnt;
                out_valid    <= 1'b0;
                out_data     <= '0;
                read_request <= '0;
                pending      <= pending & ~sel_onehot;
                rr           <= next_rr;
                state        <= ST_SELECT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pending <= ch_enable;
                            hm      <= how_many;
                            rr      <= '0;
                            busy    <= 1'b1;
                            state   <= ST_SELECT;
                        end
                    end
                    ST_SELECT: begin
                        if (!pick_any) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            sel          <= pick_idx;
                            word_cnt     <= '0;
                            settle_cnt   <= 2'(SETTLE_CYCLES);
                            first_entry  <= 1'b1;
                            read_request <= pick_onehot;
                            state        <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 2'd1) begin
                            out_valid <= 1'b1;
                            if (first_entry) begin
                                first_entry <= 1'b0;
                                out_data    <= hdr_word;
                                state       <= ST_HEADER;
                            end else begin
                                out_data <= sel_word;
                                state    <= ST_DATA;
                            end
                        end else begin
                            settle_cnt <= settle_cnt - 2'd1;
                        end
                    end
                    ST_HEADER: begin
                        // Buffer output already settled, so the first data
                        // word follows the header directly.
                        if (xfer) begin
                            out_data <= sel_word;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (xfer) begin
                            word_cnt  <= cnt_next;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            spi_done  <= sel_onehot;
                            state     <= ST_ADVANCE;
                        end
                    end
                    ST_ADVANCE: begin
                        settle_cnt <= 2'(SETTLE_CYCLES);
                        state      <= ST_SETTLE;
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : readout_sequencer

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer (NCH=4, SIZE=12, WIDTH=12). Channel i
// ring buffer returns 12'h0A0 + i*12'h100 + read address; the address moves on
// spi_done[i].
module tb_readout_sequencer;
    import readout_sequencer_pkg::*;

    localparam int NCH = 4;
    localparam int SIZE = 12;
    localparam int WIDTH = 12;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [NCH-1:0]    ch_enable;
    logic [SIZE-1:0]   how_many;
    logic [NCH-1:0]    read_request;
    logic [NCH-1:0]    spi_done;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    state_e            state_dbg;

    logic              addr_clr;
    logic [11:0]       addr [NCH];

    int n_checks = 0;
    int n_pass = 0;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [3:0]        en;
        logic [11:0]       hm;
        int                n_words;
        logic [0:7][11:0]  words;
        logic [15:0]       spi_exp;
        int                busy_cycles;
    } vec_t;

    vec_t vecs [5];

    readout_sequencer #(
        .NCH   (NCH),
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .ch_enable    (ch_enable),
        .how_many     (how_many),
        .read_request (read_request),
        .spi_done     (spi_done),
        .ch_data      (ch_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ring buffer read-address model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) addr[i] <= '0;
        end else if (addr_clr) begin
            for (int i = 0; i < NCH; i++) addr[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) if (spi_done[i]) addr[i] <= addr[i] + 12'd1;
        end
    end

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < NCH; i++) ch_data[i*WIDTH +: WIDTH] = 12'h0A0 + 12'(i * 256) + addr[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Runs one table vector with out_ready held high; called at a negedge.
    task automatic run_vec(input vec_t v, input string tag);
        int busy_n = 0;
        int words_seen = 0;
        int viol = 0;
        bit got_done = 0;
        bit prev_valid = 0;
        bit prev_xfer = 0;
        logic [15:0] spi_cnt = '0;
        exp_q.delete();
        for (int i = 0; i < v.n_words; i++) exp_q.push_back(v.words[i]);
        ch_enable = v.en;
        how_many = v.hm;
        out_ready = 1'b1;
        addr_clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1;
                check({tag, " busy at done"}, 32'(busy), 32'd0);
            end else if (busy) busy_n++;
            else viol++;
            if ($countones(read_request) > 1 || $countones(spi_done) > 1) viol++;
            if (!out_valid && out_data != '0) viol++;
            if (prev_valid && !prev_xfer && !out_valid) viol++;
            for (int i = 0; i < NCH; i++)
                if (spi_done[i]) spi_cnt[i*4 +: 4] = spi_cnt[i*4 +: 4] + 4'd1;
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0)
                    check($sformatf("%s word%0d", tag, words_seen), 32'(out_data), 32'(exp_q.pop_front()));
                words_seen++;
            end
            prev_valid = out_valid;
            prev_xfer = out_valid && out_ready;
            if (!got_done) @(negedge clk);
        end
        check({tag, " done seen"}, 32'(got_done), 32'd1);
        check({tag, " word count"}, 32'(words_seen), 32'(v.n_words));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(v.busy_cycles));
        check({tag, " spi_done counts"}, 32'(spi_cnt), 32'(v.spi_exp));
        check({tag, " invariants"}, 32'(viol), 32'd0);
        @(negedge clk);
        check({tag, " done single pulse"}, {28'd0, done, state_dbg}, {28'd0, 1'b0, ST_IDLE});
    endtask

    // Waits at negedges for a given word to be offered.
    task automatic wait_word(input logic [11:0] w, output bit found);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_data == w) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name);
        bit got = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        bit found;
        int hold_viol;
        int done_seen;

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ch_enable = '0;
        how_many = '0;
        out_ready = 1'b0;
        addr_clr = 1'b0;

        vecs[0] = '{en: 4'b0101, hm: 12'd3, n_words: 8,
                    words: '{12'hC00, 12'h0A0, 12'h0A1, 12'h0A2, 12'hC02, 12'h2A0, 12'h2A1, 12'h2A2},
                    spi_exp: 16'h0202, busy_cycles: 27};
        vecs[1] = '{en: 4'b1111, hm: 12'd0, n_words: 4,
                    words: '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'h0, 12'h0, 12'h0, 12'h0},
                    spi_exp: 16'h0000, busy_cycles: 17};
        vecs[2] = '{en: 4'b0000, hm: 12'd5, n_words: 0,
                    words: '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                    spi_exp: 16'h0000, busy_cycles: 1};
        vecs[3] = '{en: 4'b1010, hm: 12'd1, n_words: 4,
                    words: '{12'hC01, 12'h1A0, 12'hC03, 12'h3A0, 12'h0, 12'h0, 12'h0, 12'h0},
                    spi_exp: 16'h0000, busy_cycles: 11};
        vecs[4] = '{en: 4'b1000, hm: 12'd2, n_words: 3,
                    words: '{12'hC03, 12'h3A0, 12'h3A1, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                    spi_exp: 16'h1000, busy_cycles: 10};

        // reset state
        repeat (3) @(negedge clk);
        check("reset outputs", {9'd0, read_request, spi_done, out_data, out_valid, busy, done}, 32'd0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort ignored", {28'd0, done, state_dbg}, {28'd0, 1'b0, ST_IDLE});
        @(negedge clk);

        // table-driven passes
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // backpressure in DATA; a start during the pass must be ignored
        ch_enable = 4'b0001;
        how_many = 12'd2;
        out_ready = 1'b1;
        addr_clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        start = 1'b0;
        wait_word(12'h0A0, found);
        check("bp reach data", 32'(found), 32'd1);
        out_ready = 1'b0;
        ch_enable = 4'b1111;
        start = 1'b1;
        hold_viol = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!(out_valid && out_data == 12'h0A0 && spi_done == '0 && busy)) hold_viol++;
        end
        check("bp hold stable", 32'(hold_viol), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp spi_done after xfer", {28'd0, spi_done}, 32'h1);
        check("bp valid dropped", {19'd0, out_valid, out_data}, 32'd0);
        wait_word(12'h0A1, found);
        check("bp second word", 32'(found), 32'd1);
        wait_done("bp done");
        @(negedge clk);
        check("bp back idle", 32'(state_dbg), 32'(ST_IDLE));

        // abort on the 2nd data transfer of ch1
        ch_enable = 4'b0010;
        how_many = 12'd3;
        out_ready = 1'b1;
        addr_clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        start = 1'b0;
        wait_word(12'h1A1, found);
        check("abort reach word", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort outputs clear", {11'd0, read_request, spi_done, out_valid, out_data}, 32'd0);
        check("abort done pulse", {30'd0, done, busy}, 32'b10);
        check("abort state", 32'(state_dbg), 32'(ST_FINISH));
        @(negedge clk);
        check("abort done single", {28'd0, done, state_dbg}, {28'd0, 1'b0, ST_IDLE});
        run_vec(vecs[0], "post_abort");

        // reset mid-DATA
        ch_enable = 4'b0101;
        how_many = 12'd3;
        out_ready = 1'b1;
        addr_clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        start = 1'b0;
        wait_word(12'h0A1, found);
        check("rst reach word", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst async clear", {9'd0, read_request, spi_done, out_data, out_valid, busy, done}, 32'd0);
        check("rst async state", 32'(state_dbg), 32'(ST_IDLE));
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst no done", 32'(done_seen), 32'd0);
        reset_n = 1'b1;
        run_vec(vecs[0], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_readout_sequencer
